// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 frame-memory path: RGB444 pixels
// packed twice into a 24-bit word (upper-half pixel high, lower-half pixel low).
package hub75_pkg;

    localparam int PIX_W     = 12;
    localparam int WORD_W    = 24;
    localparam int UPPER_LSB = 12;
    localparam int LOWER_LSB = 0;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        WAIT_SOF  = 2'd0,
        FILL      = 2'd1,
        SWAP_WAIT = 2'd2
    } wr_state_e;

    // The byte-lane enables pick which half actually lands in memory.
    function automatic word_t replicate_pix(input pix_t p);
        word_t w;
        w = '0;
        w[UPPER_LSB +: PIX_W] = p;
        w[LOWER_LSB +: PIX_W] = p;
        return w;
    endfunction

endpackage

// File: rtl/hub75_frame_writer_if.sv
// Raster-order RGB444 pixel stream with valid/ready handshake and a
// start-of-frame qualifier on the first pixel.
interface hub75_frame_writer_if;
    import hub75_pkg::*;

    logic pix_valid;
    logic pix_ready;
    logic pix_sof;
    pix_t pix_data;

    modport master (
        output pix_valid,
        output pix_sof,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_sof,
        input  pix_data,
        output pix_ready
    );

endinterface

// File: rtl/hub75_pix_counter.sv
// Raster position counter (col fastest). clr and inc together yield the
// position following (0,0), so a restart pixel can be written and stepped past.
module hub75_pix_counter #(
    parameter  int COLS = 64,
    parameter  int ROWS = 32,
    localparam int CW   = $clog2(COLS),
    localparam int RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic [CW-1:0] base_col;
    logic [RW-1:0] base_row;
    logic [CW-1:0] col_next;
    logic [RW-1:0] row_next;

    always_comb begin
        base_col = clr ? '0 : col;
        base_row = clr ? '0 : row;
        col_next = base_col;
        row_next = base_row;
        if (inc) begin
            if (base_col == CW'(COLS - 1)) begin
                col_next = '0;
                // Power-of-2 height: the row wraps to 0 after the last pixel.
                row_next = base_row + RW'(1);
            end else begin
                col_next = base_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_next;
            row <= row_next;
        end
    end

    assign last = (col == CW'(COLS - 1)) && (row == RW'(ROWS - 1));

endmodule

// File: rtl/hub75_frame_writer.sv
// Packs a raster RGB444 stream into the scanner's 24-bit frame words and
// writes the back bank, swapping banks only on the scanner's frame boundary.
module hub75_frame_writer
    import hub75_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 32,
    parameter int AW   = $clog2(COLS * ROWS / 2) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    hub75_frame_writer_if.slave  pix,
    input  logic                 disp_frame_end,
    output logic [1:0]           mem_we,
    output logic [AW-1:0]        mem_addr,
    output word_t                mem_wdata,
    output logic                 disp_bank,
    output logic                 frame_done,
    output logic                 sof_err
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    wr_state_e     state_reg;
    wr_state_e     state_next;
    logic          accept;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_last;
    logic [CW-1:0] cnt_col;
    logic [RW-1:0] cnt_row;
    logic          wr_en;
    logic          done_next;
    logic          err_next;
    logic          bank_toggle;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] wr_row;
    logic [1:0]    lane;

    assign pix.pix_ready = (state_reg != SWAP_WAIT);
    assign accept        = pix.pix_valid & pix.pix_ready;

    hub75_pix_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .col  (cnt_col),
        .row  (cnt_row),
        .last (cnt_last)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        wr_en       = 1'b0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        bank_toggle = 1'b0;
        case (state_reg)
            WAIT_SOF: begin
                if (accept && pix.pix_sof) begin
                    wr_en      = 1'b1;
                    cnt_clr    = 1'b1;
                    cnt_inc    = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                    // A new sof wins over completion, even on the last position.
                    if (pix.pix_sof) begin
                        cnt_clr  = 1'b1;
                        err_next = 1'b1;
                    end else if (cnt_last) begin
                        done_next  = 1'b1;
                        state_next = SWAP_WAIT;
                    end
                end
            end
            SWAP_WAIT: begin
                if (disp_frame_end) begin
                    bank_toggle = 1'b1;
                    state_next  = WAIT_SOF;
                end
            end
            default: state_next = WAIT_SOF;
        endcase
    end

    assign wr_col = cnt_clr ? '0 : cnt_col;
    assign wr_row = cnt_clr ? '0 : cnt_row;

    // Lane 1 (upper half) for the top half of the panel, lane 0 for the bottom.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane[gi] = (wr_row[RW-1] == 1'(gi == 0));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= WAIT_SOF;
            disp_bank  <= 1'b0;
            mem_we     <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_we     <= wr_en ? lane : 2'b00;
            frame_done <= done_next;
            sof_err    <= err_next;
            if (wr_en) begin
                mem_addr  <= AW'({~disp_bank, wr_row[RW-2:0], wr_col});
                mem_wdata <= replicate_pix(pix.pix_data);
            end
            if (bank_toggle) begin
                disp_bank <= ~disp_bank;
            end
        end
    end

endmodule

// File: tb/tb_hub75_frame_writer.sv
// Scoreboard bench for hub75_frame_writer on a 4x4 panel: expected writes are
// queued by the stimulus and checked by an independent monitor.
module tb_hub75_frame_writer;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int AW   = 4;

    typedef struct packed {
        logic [1:0]    we;
        logic [AW-1:0] addr;
        logic [23:0]   wdata;
        logic          fd;
        logic          se;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_frame_end = 1'b0;
    logic [1:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          disp_bank;
    logic          frame_done;
    logic          sof_err;

    int  total = 0;
    int  bad   = 0;
    wr_t expq[$];

    hub75_frame_writer_if pif ();

    hub75_frame_writer #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix            (pif.slave),
        .disp_frame_end (disp_frame_end),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .disp_bank      (disp_bank),
        .frame_done     (frame_done),
        .sof_err        (sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Pixel index -> {bank, row mod 2, col}; bottom half rows use lane 01.
    task automatic expect_wr(input int idx, input logic bank, input logic [11:0] d,
                             input logic fd, input logic se);
        logic [3:0] i4;
        wr_t        w;
        i4      = idx[3:0];
        w.we    = i4[3] ? 2'b01 : 2'b10;
        w.addr  = {bank, i4[2], i4[1:0]};
        w.wdata = {d, d};
        w.fd    = fd;
        w.se    = se;
        expq.push_back(w);
    endtask

    task automatic send(input logic [11:0] d, input logic sof);
        int k;
        k = 0;
        while (!pif.pix_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!pif.pix_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        pif.pix_valid = 1'b1;
        pif.pix_data  = d;
        pif.pix_sof   = sof;
        @(posedge clk);
        #1;
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;
    endtask

    task automatic swap_pulse();
        disp_frame_end = 1'b1;
        @(posedge clk);
        #1;
        disp_frame_end = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && (mem_we != 2'b00 || frame_done || sof_err)) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL write: got we=%b addr=%0h data=%0h fd=%b se=%b expected none",
                         mem_we, mem_addr, mem_wdata, frame_done, sof_err);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if ({mem_we, mem_addr, mem_wdata, frame_done, sof_err} !== e) begin
                    bad++;
                    $display("FAIL write: got we=%b addr=%0h data=%0h fd=%b se=%b expected we=%b addr=%0h data=%0h fd=%b se=%b",
                             mem_we, mem_addr, mem_wdata, frame_done, sof_err,
                             e.we, e.addr, e.wdata, e.fd, e.se);
                end else begin
                    $display("ok   write we=%b addr=%0h data=%0h fd=%b se=%b",
                             mem_we, mem_addr, mem_wdata, frame_done, sof_err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pif.pix_valid = 1'b0;
        pif.pix_sof   = 1'b0;
        pif.pix_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(pif.pix_ready), 32'd1);
        chk("rst_bank", 32'(disp_bank), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_pulses", 32'({frame_done, sof_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame A: back bank is 1
        for (int i = 0; i < 16; i++) begin
            expect_wr(i, 1'b1, 12'(i), i == 15, 1'b0);
            send(12'(i), i == 0);
        end
        chk("a_ready_low", 32'(pif.pix_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("a_ready_hold", 32'(pif.pix_ready), 32'd0);
        swap_pulse();
        chk("swap1_bank", 32'(disp_bank), 32'd1);
        chk("swap1_ready", 32'(pif.pix_ready), 32'd1);

        // Frame B: back bank is 0
        for (int i = 0; i < 16; i++) begin
            expect_wr(i, 1'b0, 12'(12'h100 + i), i == 15, 1'b0);
            send(12'(12'h100 + i), i == 0);
        end
        swap_pulse();
        chk("swap2_bank", 32'(disp_bank), 32'd0);

        // Dropped pixels, then frame C aborted by sof at pixel 5
        for (int i = 0; i < 3; i++) send(12'hFFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            expect_wr(i, 1'b1, 12'(12'h200 + i), 1'b0, 1'b0);
            send(12'(12'h200 + i), i == 0);
        end
        expect_wr(0, 1'b1, 12'h2AA, 1'b0, 1'b1);
        send(12'h2AA, 1'b1);
        for (int i = 1; i < 16; i++) begin
            expect_wr(i, 1'b1, 12'(12'h300 + i), i == 15, 1'b0);
            send(12'(12'h300 + i), 1'b0);
        end
        chk("c_ready_low", 32'(pif.pix_ready), 32'd0);
        swap_pulse();
        chk("swap3_bank", 32'(disp_bank), 32'd1);

        // Frame E: reset after pixel 10
        for (int i = 0; i < 10; i++) begin
            expect_wr(i, 1'b0, 12'(12'h400 + i), 1'b0, 1'b0);
            send(12'(12'h400 + i), i == 0);
        end
        @(negedge clk);
        #1;
        chk("e_queue_empty", 32'(expq.size()), 32'd0);
        rst = 1'b1;
        #1;
        chk("e_rst_bank", 32'(disp_bank), 32'd0);
        chk("e_rst_we", 32'(mem_we), 32'd0);
        chk("e_rst_addr", 32'(mem_addr), 32'd0);
        chk("e_rst_wdata", mem_wdata, 32'd0);
        chk("e_rst_ready", 32'(pif.pix_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame D: stalls, stray disp_frame_end and sof-without-valid in gaps
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = (i == 0) ? 0 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                disp_frame_end = 1'b1;
                pif.pix_sof    = 1'b1;
                @(posedge clk);
                #1;
                disp_frame_end = 1'b0;
                pif.pix_sof    = 1'b0;
            end
            expect_wr(i, 1'b1, 12'(12'h500 + i), i == 15, 1'b0);
            send(12'(12'h500 + i), i == 0);
        end
        chk("d_bank_kept", 32'(disp_bank), 32'd0);
        swap_pulse();
        chk("swap4_bank", 32'(disp_bank), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hub75_frame_writer.md
# hub75_frame_writer

Write-side counterpart of the HUB75 bit-plane readout. Accepts a raster-order RGB444 pixel stream and packs each pixel into the 24-bit frame-memory word format the scanner reads: upper-half pixel in [23:12] (R0[23:20] G0[19:16] B0[15:12]), lower-half pixel in [11:0] (R1[11:8] G1[7:4] B1[3:0]). Manages a two-bank frame buffer: it writes the back bank and swaps banks only on the scanner's frame boundary.

## Interface
- COLS, 64, panel width in pixels (power of 2)
- ROWS, 32, panel height in pixels (power of 2, even); word-rows per bank = ROWS/2
- AW, log2(COLS*ROWS/2)+1, memory address width (MSB = bank)

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel present
- pix_ready  out  1  writer accepts pixel this cycle
- pix_data  in  12  R[11:8] G[7:4] B[3:0]
- pix_sof  in  1  qualifies the first pixel of a frame (valid only with pix_valid)
- disp_frame_end  in  1  one-cycle pulse from scanner: full frame displayed, swap allowed
- mem_we  out  2  [1] writes word bits [23:12], [0] writes [11:0]
- mem_addr  out  AW  {bank, row mod ROWS/2, col}
- mem_wdata  out  24  pixel replicated in both halves
- disp_bank  out  1  bank the scanner reads; writer always targets ~disp_bank
- frame_done  out  1  one-cycle pulse: last pixel of frame written
- sof_err  out  1  one-cycle pulse: pix_sof arrived mid-frame

## Operation
- Accept = pix_valid & pix_ready. pix_ready = (state != SWAP_WAIT); decoded from registered state only.
- States:
  - WAIT_SOF: accepts without sof are dropped (no write). Accept with sof -> write at col 0 row 0, go FILL.
  - FILL: each accept writes at current (row, col), then col+1; col wraps COLS-1 -> 0 with row+1. Accept of pixel (ROWS-1, COLS-1) -> frame_done, go SWAP_WAIT.
  - SWAP_WAIT: no accepts. disp_frame_end -> disp_bank toggles, go WAIT_SOF.
- Write lane: row < ROWS/2 -> mem_we=2'b10; else mem_we=2'b01. Address row field = row mod ROWS/2 (drop row MSB).
- Boundaries:
  - pix_sof during FILL: sof_err pulse; counters restart, this pixel written at (0,0); stay FILL. No frame_done for the aborted frame.
  - pix_sof on the last pixel position: treated as restart (sof_err), not completion.
  - disp_frame_end outside SWAP_WAIT: ignored, not latched.
  - pix_sof without pix_valid: ignored.
  - Reset mid-frame: all state cleared; partial back-bank contents are left as is, next frame overwrites.

## Timing
- Reset values: state WAIT_SOF, row=col=0, disp_bank 0, mem_we 0, mem_addr 0, mem_wdata 0, frame_done 0, sof_err 0, pix_ready 1.
- Write latency 1: mem_we/mem_addr/mem_wdata registered, valid the cycle after accept; mem_we is 0 in every cycle without a write.
- frame_done and sof_err coincide with the corresponding write cycle.
- Throughput: one pixel per clock in FILL.
- pix_ready drops the cycle after the last pixel is accepted, and rises the cycle after disp_frame_end is sampled in SWAP_WAIT. disp_bank changes on that same edge.

## Structure
- Shared package hub75_pkg: RGB444 pixel width (12), packed word width (24), half-word field offsets (upper 12, lower 0), writer state enum {WAIT_SOF, FILL, SWAP_WAIT}.
- One sub-module: hub75_pix_counter (col/row counter with clear, increment, last-pixel flag; parameterised COLS, ROWS).

## Test plan
Benches use COLS=4, ROWS=4.
- Reset, then a full frame: sof + 16 pixels, data = index -> writes at addr 8..15 (bank 1), mem_we 10 for pixels 0-7 and 01 for pixels 8-15; frame_done with last write; pix_ready 0 afterwards.
- In SWAP_WAIT, pulse disp_frame_end -> disp_bank 0->1 next edge, pix_ready 1; the next frame writes addr 0..7.
- Pixels without sof in WAIT_SOF (data 0xFFF x3) -> mem_we stays 0; first sof pixel goes to addr 8, mem_wdata 24'h…
- Sof at pixel 5 of a frame -> sof_err pulse, that pixel written at addr 8, lane 10; frame_done only after 16 further pixels.
- pix_valid toggled randomly, disp_frame_end pulsed during FILL -> ignored, no bank change; pixel order and addresses unaffected by stalls.
- Assert rst at pixel 10 -> all outputs at reset values, disp_bank 0; next sof frame starts at addr 8.
